// File: rtl/booth_mul_arbiter.sv
// Round-robin front end for one shared combinational Booth multiplier.
// Ports: clk, rst_n (sync, active-low); req_valid_i/req_ready_o/req_a_i/req_b_i
// per-client request channel; mul_a_o/mul_b_o/mul_p_i to the multiplier;
// rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_result_o response channel;
// busy_o when either stage holds work; ops_cnt_o saturating completion count.
module booth_mul_arbiter #(
    parameter int N    = 10,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*N-1:0] req_a_i,
    input  logic [NREQ*N-1:0] req_b_i,
    output logic [N-1:0]      mul_a_o,
    output logic [N-1:0]      mul_b_o,
    input  logic [2*N-1:0]    mul_p_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [2*N-1:0]    rsp_result_o,
    output logic              busy_o,
    output logic [15:0]       ops_cnt_o
);

    logic            v1_q, v1_d;
    logic [IDW-1:0]  id1_q, id1_d;
    logic [N-1:0]    a1_q, a1_d;
    logic [N-1:0]    b1_q, b1_d;
    logic            v2_q, v2_d;
    logic [IDW-1:0]  id2_q, id2_d;
    logic [2*N-1:0]  p2_q, p2_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            s2_free;
    logic            s1_adv;
    logic            s1_free;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW:0]    scan;
    logic            accept;
    logic            drain;

    assign s2_free = !v2_q || rsp_ready_i;
    assign s1_adv  = v1_q && s2_free;
    assign s1_free = !v1_q || s1_adv;
    assign drain   = v2_q && rsp_ready_i;

    // Scan from the round-robin pointer; one extra bit lets the sum wrap
    // correctly for non-power-of-two NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_q} + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid_i[scan[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IDW-1:0];
            end
        end
    end

    // Grants are suppressed while reset is held so nothing is lost.
    assign accept      = gnt_found && s1_free && rst_n;
    assign req_ready_o = accept ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        v1_d  = v1_q;
        id1_d = id1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        v2_d  = v2_q;
        id2_d = id2_q;
        p2_d  = p2_q;
        rr_d  = rr_q;
        cnt_d = cnt_q;

        if (accept) begin
            v1_d  = 1'b1;
            id1_d = gnt_idx;
            a1_d  = req_a_i[gnt_idx*N +: N];
            b1_d  = req_b_i[gnt_idx*N +: N];
            rr_d  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
        end else if (s1_adv) begin
            v1_d = 1'b0;
        end

        if (s1_adv) begin
            v2_d  = 1'b1;
            id2_d = id1_q;
            p2_d  = mul_p_i;
        end else if (drain) begin
            v2_d = 1'b0;
        end

        if (drain && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            id1_q <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            v2_q  <= 1'b0;
            id2_q <= '0;
            p2_q  <= '0;
            rr_q  <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            id1_q <= id1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            v2_q  <= v2_d;
            id2_q <= id2_d;
            p2_q  <= p2_d;
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    // Operands stay parked on the multiplier after S1 empties.
    assign mul_a_o      = a1_q;
    assign mul_b_o      = b1_q;
    assign rsp_valid_o  = v2_q;
    assign rsp_id_o     = id2_q;
    assign rsp_result_o = p2_q;
    assign busy_o       = v1_q || v2_q;
    assign ops_cnt_o    = cnt_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: queue-level reference model compared every
// cycle, plus directed literal checks and randomized traffic.
module tb_booth_mul_arbiter;

    localparam int N    = 10;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*N-1:0]      req_a, req_b;
    logic [N-1:0]           mul_a, mul_b;
    logic signed [2*N-1:0]  mul_p;
    logic                   rsp_valid, rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [2*N-1:0]         rsp_result;
    logic                   busy;
    logic [15:0]            ops_cnt;

    logic signed [N-1:0] ra [NREQ];
    logic signed [N-1:0] rb [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_a[gi*N +: N] = ra[gi];
        assign req_b[gi*N +: N] = rb[gi];
    end

    // Stand-in for the external multiplier.
    assign mul_p = $signed(mul_a) * $signed(mul_b);

    booth_mul_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
        .busy_o(busy), .ops_cnt_o(ops_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: in-order list of in-flight jobs; s2 marks the one
    // currently presented on the response channel.
    typedef struct {
        int         id;
        logic [19:0] p;
        bit         s2;
    } item_t;

    item_t      q[$];
    int         rr_m = 0;
    int         cnt_m = 0;
    logic [N-1:0] la = '0, lb = '0;
    int         last_g = -1;
    bit         pending [NREQ];

    function automatic int grant_m();
        if (!rst_n) return -1;
        if (!(q.size() < 2 || rsp_ready)) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(rr_m + k) % NREQ]) return (rr_m + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        rr_m = 0;
        cnt_m = 0;
        la = '0;
        lb = '0;
    endtask

    // Check outputs mid-cycle, then advance DUT and model by one edge.
    task automatic cycle();
        int g;
        int prod;
        item_t it;
        bit out_v;
        #1;
        g = grant_m();
        out_v = (q.size() > 0) && q[0].s2;
        chk("req_ready", req_ready, (g >= 0) ? (longint'(1) << g) : 0);
        chk("rsp_valid", rsp_valid, out_v);
        if (out_v) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_result", rsp_result, q[0].p);
        end
        chk("busy", busy, q.size() > 0);
        chk("ops_cnt", ops_cnt, cnt_m);
        chk("mul_a", mul_a, la);
        chk("mul_b", mul_b, lb);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
            g = -1;
        end else begin
            if (q.size() > 0 && q[0].s2 && rsp_ready) begin
                void'(q.pop_front());
                if (cnt_m < 65535) cnt_m++;
            end
            if (q.size() == 1 && !q[0].s2) q[0].s2 = 1'b1;
            if (g >= 0) begin
                prod = int'(ra[g]) * int'(rb[g]);
                it.id = g;
                it.p = prod[19:0];
                it.s2 = 1'b0;
                q.push_back(it);
                la = ra[g];
                lb = rb[g];
                rr_m = (g + 1) % NREQ;
            end
        end
        last_g = g;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic one_req(input int id, input int a, input int b,
                           input logic [19:0] exp, input string nm);
        req_valid = '0;
        req_valid[id] = 1'b1;
        ra[id] = N'(a);
        rb[id] = N'(b);
        rsp_ready = 1'b1;
        cycle();
        chk({nm, "_grant"}, last_g, id);
        req_valid = '0;
        #1 chk({nm, "_lat_t1"}, rsp_valid, 0);
        cycle();
        #1 chk({nm, "_valid"}, rsp_valid, 1);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_result"}, rsp_result, exp);
        cycle();
    endtask

    function automatic logic signed [N-1:0] pick_op();
        case ($urandom_range(0, 7))
            0: return -10'sd512;
            1: return 10'sd511;
            2: return '0;
            3: return -10'sd1;
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        logic [19:0] held_r;
        logic [IDW-1:0] held_id;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
            pending[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ops_cnt", ops_cnt, 0);
        chk("rst_mul_a", mul_a, 0);

        // Single request and operand boundaries.
        one_req(2, 3, -4, 20'hFFFF4, "single");
        #1 chk("single_ops_cnt", ops_cnt, 1);
        one_req(0, -512, -512, 20'h40000, "minmin");
        one_req(1, 511, -512, 20'(-261632), "maxmin");
        one_req(3, 0, -1, 20'h00000, "zero");

        // Fairness from a fresh pointer.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = pick_op();
                rb[i] = pick_op();
            end
            cycle();
            chk("fair_grant", last_g, k % NREQ);
        end
        req_valid = '0;
        repeat (3) cycle();

        // Backpressure: two fill the pipe, the third waits.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        ra[1] = 10'sd7;
        rb[1] = -10'sd3;
        cycle();
        chk("bp_acc1", last_g, 1);
        ra[1] = 10'sd5;
        rb[1] = 10'sd6;
        cycle();
        chk("bp_acc2", last_g, 1);
        ra[1] = -10'sd2;
        rb[1] = 10'sd9;
        cycle();
        chk("bp_stall", last_g, -1);
        held_r = rsp_result;
        held_id = rsp_id;
        chk("bp_head", rsp_result, 20'hFFFEB);
        repeat (3) cycle();
        #1 chk("bp_ready0", req_ready, 0);
        chk("bp_hold_r", rsp_result, held_r);
        chk("bp_hold_id", rsp_id, held_id);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_acc3", last_g, 1);
        req_valid = '0;
        #1 chk("bp_second", rsp_result, 20'd30);
        repeat (3) cycle();

        // Reset with two jobs in flight.
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (2) cycle();
        do_reset();
        #1 chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", ops_cnt, 0);
        req_valid = 4'b1001;
        cycle();
        chk("mid_rst_rr", last_g, 0);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        cycle();
        chk("mid_rst_next", last_g, 3);
        req_valid = '0;
        repeat (4) cycle();

        // Randomized traffic with occasional resets.
        req_valid = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    ra[i] = pick_op();
                    rb[i] = pick_op();
                end
                req_valid[i] = pending[i];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
            rst_n = 1'b1;
            if (last_g >= 0) pending[last_g] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cycle();

        // Drive the completion counter to saturation.
        do_reset();
        req_valid = 4'b0001;
        ra[0] = 10'sd1;
        rb[0] = 10'sd1;
        for (int c = 0; c < 70000 && cnt_m < 65535; c++) cycle();
        repeat (4) cycle();
        #1 chk("sat_cnt", ops_cnt, 16'hFFFF);
        req_valid = '0;
        repeat (2) cycle();
        #1 chk("sat_hold", ops_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
